spi_codeword_rx: RTL and testbench

SPI slave receive front-end that deserialises 7-bit Hamming codewords from an external master and delivers them, one per handshake, to `hamming_decoder`. SPI pins are oversampled in the system clock domain, completed codewords are queued in a small FIFO, and a valid/ready interface presents them to the decoder stage directly downstream. Framing and overrun faults are flagged as single-cycle pulses.

---
 rtl/spi_pkg.sv | 15 +
 rtl/spi_codeword_rx_sync_fifo.sv | 70 +++++++
 rtl/spi_codeword_rx.sv | 175 +++++++++++++++++
 tb/tb_spi_codeword_rx.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI codeword receive path.
package spi_pkg;

  localparam int unsigned CW_WIDTH  = 7;
  localparam int unsigned BIT_CNT_W = 3;

  typedef logic [CW_WIDTH-1:0] cw_t;

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    SHIFT     = 2'd2
  } rx_state_e;

endpackage

// File: rtl/spi_codeword_rx_sync_fifo.sv
// Show-ahead FIFO with registered head output, full flag and synchronous flush.
module sync_fifo #(
  parameter int unsigned WIDTH = 7,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             flush_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_ptr_nxt_c;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] remain_c;
  logic [CNT_W-1:0] count_nxt_c;
  logic             pop_c;
  logic             push_c;

  // Accept a push when there is room, or when a pop frees a slot this cycle.
  always_comb begin
    pop_c        = pop & valid;
    push_c       = push & (~full | pop_c);
    remain_c     = count - CNT_W'(pop_c);
    count_nxt_c  = remain_c + CNT_W'(push_c);
    rd_ptr_nxt_c = rd_ptr + PTR_W'(pop_c);
  end

  // Storage array, written without reset.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers, occupancy and the registered head word.
  always_ff @(posedge clk) begin
    if (!flush_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= 1'b0;
      full   <= 1'b0;
      dout   <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(push_c);
      rd_ptr <= rd_ptr_nxt_c;
      count  <= count_nxt_c;
      valid  <= (count_nxt_c != '0);
      full   <= (count_nxt_c == CNT_W'(DEPTH));
      if (remain_c == '0) begin
        if (push_c) begin
          dout <= din;
        end
      end else begin
        dout <= mem[rd_ptr_nxt_c];
      end
    end
  end

endmodule

// File: rtl/spi_codeword_rx.sv
// SPI mode-0 slave receiver: oversamples pins, deserialises 7-bit codewords,
// queues them and hands them downstream over valid/ready.
// Build option SPI_RX_LSB_FIRST_EN: shift bits in LSB-first instead of MSB-first.
module spi_codeword_rx
  import spi_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                spi_sclk,
  input  logic                spi_cs_n,
  input  logic                spi_mosi,
  output logic [CW_WIDTH-1:0] cw_data,
  output logic                cw_valid,
  input  logic                cw_ready,
  output logic                overrun,
  output logic                frame_err
);

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_s;
  logic                   cs_s;
  logic                   mosi_s;

  logic                   sclk_d;
  logic                   cs_d;
  logic                   sclk_rise;
  logic                   cs_fall;
  logic                   cs_rise;
  logic                   mosi_q;

  rx_state_e              state_q;
  rx_state_e              state_nxt_c;
  cw_t                    sr_q;
  cw_t                    sr_nxt_c;
  cw_t                    shifted_c;
  logic [BIT_CNT_W-1:0]   bit_cnt_q;
  logic [BIT_CNT_W-1:0]   cnt_nxt_c;
  logic                   push_c;
  logic                   frame_err_c;
  logic                   push_q;
  cw_t                    push_word_q;
  logic                   fifo_full;

  // Input synchronisers; cs_n resets low so a frame in progress is not mistaken for idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
    end
  end

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  // Registered edge detection; sclk edges are only honoured while cs_n is low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_d    <= 1'b0;
      cs_d      <= 1'b0;
      sclk_rise <= 1'b0;
      cs_fall   <= 1'b0;
      cs_rise   <= 1'b0;
      mosi_q    <= 1'b0;
    end else begin
      sclk_d    <= sclk_s;
      cs_d      <= cs_s;
      sclk_rise <= sclk_s & ~sclk_d & ~cs_s;
      cs_fall   <= ~cs_s & cs_d;
      cs_rise   <= cs_s & ~cs_d;
      mosi_q    <= mosi_s;
    end
  end

  // Receiver state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= WAIT_IDLE;
    end else begin
      state_q <= state_nxt_c;
    end
  end

  // Next-state: wait out any interrupted frame, then track cs_n framing.
  always_comb begin
    state_nxt_c = state_q;
    case (state_q)
      WAIT_IDLE: if (cs_d)    state_nxt_c = IDLE;
      IDLE:      if (cs_fall) state_nxt_c = SHIFT;
      SHIFT:     if (cs_rise) state_nxt_c = IDLE;
      default:                state_nxt_c = WAIT_IDLE;
    endcase
  end

  // Datapath decisions: shift, push on the seventh bit, flag short frames.
  always_comb begin
`ifdef SPI_RX_LSB_FIRST_EN
    shifted_c = {mosi_q, sr_q[CW_WIDTH-1:1]};
`else
    shifted_c = {sr_q[CW_WIDTH-2:0], mosi_q};
`endif
    sr_nxt_c    = sr_q;
    cnt_nxt_c   = bit_cnt_q;
    push_c      = 1'b0;
    frame_err_c = 1'b0;
    case (state_q)
      SHIFT: begin
        if (cs_rise) begin
          frame_err_c = (bit_cnt_q != '0);
          cnt_nxt_c   = '0;
        end else if (sclk_rise) begin
          sr_nxt_c = shifted_c;
          if (bit_cnt_q == BIT_CNT_W'(CW_WIDTH - 1)) begin
            push_c    = 1'b1;
            cnt_nxt_c = '0;
          end else begin
            cnt_nxt_c = bit_cnt_q + BIT_CNT_W'(1);
          end
        end
      end
      default: cnt_nxt_c = '0;
    endcase
  end

  // Datapath registers and the completed-word strobe toward the FIFO.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr_q        <= '0;
      bit_cnt_q   <= '0;
      push_q      <= 1'b0;
      push_word_q <= '0;
      frame_err   <= 1'b0;
    end else begin
      sr_q        <= sr_nxt_c;
      bit_cnt_q   <= cnt_nxt_c;
      push_q      <= push_c;
      push_word_q <= shifted_c;
      frame_err   <= frame_err_c;
    end
  end

  // Overrun: a push arrives while full and no pop frees a slot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else begin
      overrun <= push_q & fifo_full & ~(cw_valid & cw_ready);
    end
  end

  sync_fifo #(
    .WIDTH (CW_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .flush_n (rst_n),
    .push    (push_q),
    .din     (push_word_q),
    .pop     (cw_ready),
    .dout    (cw_data),
    .valid   (cw_valid),
    .full    (fifo_full)
  );

endmodule

// File: tb/tb_spi_codeword_rx.sv
// Self-checking bench for spi_codeword_rx: directed scenarios plus random frames
// checked against a bit-stream reference model.
module tb_spi_codeword_rx;

  localparam int unsigned FIFO_DEPTH  = 4;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned HALF        = 4;

  typedef bit bitq_t[$];

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       spi_sclk = 1'b0;
  logic       spi_cs_n = 1'b1;
  logic       spi_mosi = 1'b0;
  logic       cw_ready = 1'b0;
  logic [6:0] cw_data;
  logic       cw_valid;
  logic       overrun;
  logic       frame_err;

  int unsigned cyc         = 0;
  int          vectors     = 0;
  int          miscompares = 0;

  logic [6:0]  got_q[$];
  int unsigned pop_cyc_q[$];
  logic [6:0]  exp_q[$];
  int          exp_fe         = 0;
  int          ovr_cnt        = 0;
  int          fe_cnt         = 0;
  int          valid_hi_cnt   = 0;
  int unsigned valid_rise_cyc = 0;
  int unsigned last_rise_cyc  = 0;
  logic        valid_prev     = 1'b0;
  logic        hold_prev      = 1'b0;
  logic [6:0]  data_prev      = '0;
  bit          rand_ready     = 1'b0;

  spi_codeword_rx #(
    .FIFO_DEPTH  (FIFO_DEPTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .spi_sclk  (spi_sclk),
    .spi_cs_n  (spi_cs_n),
    .spi_mosi  (spi_mosi),
    .cw_data   (cw_data),
    .cw_valid  (cw_valid),
    .cw_ready  (cw_ready),
    .overrun   (overrun),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe handshakes and flag pulses; also check the head holds while stalled.
  always @(negedge clk) begin
    if (cw_valid && cw_ready) begin
      got_q.push_back(cw_data);
      pop_cyc_q.push_back(cyc);
    end
    if (overrun)   ovr_cnt++;
    if (frame_err) fe_cnt++;
    if (cw_valid)  valid_hi_cnt++;
    if (cw_valid && !valid_prev) valid_rise_cyc = cyc;
    if (hold_prev && rst_n) begin
      vectors++;
      assert (cw_valid === 1'b1 && cw_data === data_prev) else begin
        miscompares++;
        $error("FAIL hold_stable: observed valid=%b data=%h expected valid=1 data=%h",
               cw_valid, cw_data, data_prev);
      end
    end
    hold_prev  = cw_valid && !cw_ready;
    data_prev  = cw_data;
    valid_prev = cw_valid;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n cycles, landing 2 time units after a rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
      if (rand_ready) cw_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic clear_mon();
    got_q.delete();
    pop_cyc_q.delete();
    exp_q.delete();
    exp_fe       = 0;
    ovr_cnt      = 0;
    fe_cnt       = 0;
    valid_hi_cnt = 0;
  endtask

  // Reference rule: the first received bit lands in bit 6 (bit 0 for LSB-first).
  function automatic logic [6:0] model_word(input bitq_t b, input int base);
    logic [6:0] w;
    w = '0;
    for (int i = 0; i < 7; i++) begin
`ifdef SPI_RX_LSB_FIRST_EN
      w[i] = b[base + i];
`else
      w[6 - i] = b[base + i];
`endif
    end
    return w;
  endfunction

  function automatic bitq_t w2bits(input logic [6:0] w);
    bitq_t q;
    for (int i = 6; i >= 0; i--) q.push_back(w[i]);
    return q;
  endfunction

  task automatic send_bit(input bit b);
    spi_mosi = b;
    tick(HALF);
    spi_sclk      = 1'b1;
    last_rise_cyc = cyc;
    tick(HALF);
    spi_sclk = 1'b0;
  endtask

  task automatic cs_start();
    spi_cs_n = 1'b0;
    tick(HALF);
  endtask

  task automatic cs_end();
    tick(HALF);
    spi_cs_n = 1'b1;
    tick(2 * HALF);
  endtask

  // One CS frame; expectations derived from the bit stream before sending.
  task automatic send_frame(input bitq_t b);
    for (int k = 0; k + 7 <= b.size(); k += 7) exp_q.push_back(model_word(b, k));
    if ((b.size() % 7) != 0) exp_fe++;
    cs_start();
    foreach (b[i]) send_bit(b[i]);
    cs_end();
  endtask

  initial begin
    bitq_t      s;
    logic [6:0] w;
    int         n;

    // Reset state
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(2);
    check("rst_cw_valid",  32'(cw_valid),  32'd0);
    check("rst_cw_data",   32'(cw_data),   32'd0);
    check("rst_overrun",   32'(overrun),   32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    tick(8);

    // Single codeword, consumer always ready, latency from 7th sclk rise
    clear_mon();
    cw_ready = 1'b1;
`ifdef SPI_RX_LSB_FIRST_EN
    s = '{1, 0, 0, 1, 1, 0, 0};
`else
    s = '{0, 0, 1, 1, 0, 0, 1};
`endif
    send_frame(s);
    tick(10);
    check("t1_count",   32'(got_q.size()), 32'd1);
    if (got_q.size() > 0) check("t1_word", 32'(got_q[0]), 32'b0011001);
    check("t1_latency", valid_rise_cyc - last_rise_cyc, SYNC_STAGES + 3);
    check("t1_valid_cycles", 32'(valid_hi_cnt), 32'd1);
    check("t1_flags", 32'(ovr_cnt + fe_cnt), 32'd0);

    // Three back-to-back codewords held, then drained on consecutive cycles
    clear_mon();
    cw_ready = 1'b0;
    s = {w2bits(7'h19), w2bits(7'h7F), w2bits(7'h00)};
    send_frame(s);
    tick(6);
    check("t2_no_pop",  32'(got_q.size()), 32'd0);
    check("t2_valid",   32'(cw_valid), 32'd1);
    check("t2_head",    32'(cw_data), 32'(exp_q[0]));
    cw_ready = 1'b1;
    tick(6);
    check("t2_count", 32'(got_q.size()), 32'd3);
    for (int i = 0; i < 3 && i < got_q.size(); i++)
      check($sformatf("t2_word%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
    if (pop_cyc_q.size() == 3) begin
      check("t2_gap01", pop_cyc_q[1] - pop_cyc_q[0], 32'd1);
      check("t2_gap12", pop_cyc_q[2] - pop_cyc_q[1], 32'd1);
    end
    check("t2_valid_after", 32'(cw_valid), 32'd0);

    // Five codewords into a depth-4 FIFO with no consumer
    clear_mon();
    cw_ready = 1'b0;
    s.delete();
    for (int i = 0; i < 5; i++) s = {s, w2bits(7'($urandom))};
    send_frame(s);
    tick(6);
    check("t3_overrun", 32'(ovr_cnt), 32'd1);
    cw_ready = 1'b1;
    tick(8);
    check("t3_count", 32'(got_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < got_q.size(); i++)
      check($sformatf("t3_word%0d", i), 32'(got_q[i]), 32'(exp_q[i]));

    // Short frame, then a good frame
    clear_mon();
    cw_ready = 1'b1;
    s.delete();
    for (int i = 0; i < 4; i++) s.push_back(1'($urandom));
    send_frame(s);
    send_frame(w2bits(7'h2A));
    tick(8);
    check("t4_frame_err", 32'(fe_cnt), 32'd1);
    check("t4_count", 32'(got_q.size()), 32'd1);
    if (got_q.size() > 0) check("t4_word", 32'(got_q[0]), 32'(exp_q[0]));

    // Reset mid-frame flushes the FIFO and ignores the rest of the frame
    clear_mon();
    cw_ready = 1'b0;
    send_frame(w2bits(7'h55));
    tick(4);
    cs_start();
    for (int i = 0; i < 3; i++) send_bit(1'($urandom));
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    check("t5_flushed", 32'(cw_valid), 32'd0);
    cw_ready = 1'b1;
    got_q.delete();
    for (int i = 0; i < 4; i++) send_bit(1'($urandom));
    cs_end();
    tick(8);
    check("t5_no_word", 32'(got_q.size()), 32'd0);
    check("t5_no_flags", 32'(ovr_cnt + fe_cnt), 32'd0);
    clear_mon();
    w = 7'($urandom);
    send_frame(w2bits(w));
    tick(8);
    check("t5_after_count", 32'(got_q.size()), 32'd1);
    if (got_q.size() > 0) check("t5_after_word", 32'(got_q[0]), 32'(exp_q[0]));

    // Random frames with random consumer stalls
    clear_mon();
    rand_ready = 1'b1;
    for (int f = 0; f < 40; f++) begin
      s.delete();
      n = int'($urandom_range(0, 2));
      for (int i = 0; i < 7 * n; i++) s.push_back(1'($urandom));
      if (($urandom % 3) == 0 || n == 0) begin
        for (int i = 0; i < int'($urandom_range(1, 6)); i++) s.push_back(1'($urandom));
      end
      send_frame(s);
    end
    rand_ready = 1'b0;
    cw_ready   = 1'b1;
    tick(12);
    check("rnd_count", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check($sformatf("rnd_word%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
    check("rnd_frame_err", 32'(fe_cnt), 32'(exp_fe));
    check("rnd_overrun", 32'(ovr_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
